// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS-subset datapath: sequences fetch/decode/execute/
// memory/writeback, drives datapath selects and enables, and counts retired/illegal instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Moore control word for a state; only EXEC looks at funct.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_ctrl  = 3'b010;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_ctrl  = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctrl  = 3'b010;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                case (fn)
                    FN_ADD:  c.alu_ctrl = 3'b010;
                    FN_SUB:  c.alu_ctrl = 3'b110;
                    FN_AND:  c.alu_ctrl = 3'b000;
                    FN_OR:   c.alu_ctrl = 3'b001;
                    FN_SLT:  c.alu_ctrl = 3'b111;
                    default: c.alu_ctrl = 3'b000;
                endcase
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = 3'b110;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t            r_state;
    ctrl_t             r_ctrl;
    logic [CNT_W-1:0]  r_retired;
    logic              r_illegal;

    state_t            w_state_next;
    logic              w_retire;
    logic              w_illegal_op;
    logic              w_rtype_ok;
    logic              w_state_valid;
    ctrl_t             w_ctrl;

    always_comb begin
        w_rtype_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);
    end

    always_comb begin
        w_state_next = S_FETCH;
        w_retire     = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: w_state_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    w_state_next = S_MEMADR;
                end else if (opcode == OP_RTYPE && w_rtype_ok) begin
                    w_state_next = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    w_state_next = S_BRANCH;
                end else if (opcode == OP_ADDI) begin
                    w_state_next = S_ADDIEX;
                end else if (opcode == OP_J) begin
                    w_state_next = S_JUMP;
                end else begin
                    w_state_next = S_FETCH;
                    w_illegal_op = 1'b1;
                end
            end
            S_MEMADR: w_state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_state_next = S_MEMWB;
            S_EXEC:   w_state_next = S_ALUWB;
            S_ADDIEX: w_state_next = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctrl    <= decode_ctrl(S_FETCH, 6'b000000);
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= decode_ctrl(w_state_next, funct);
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_illegal_op) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // An upset into an unused code must not leave stale enables driving the datapath.
    assign w_state_valid = (r_state <= S_JUMP);
    assign w_ctrl        = w_state_valid ? r_ctrl : '0;

    assign pc_en      = w_ctrl.pc_write | (w_ctrl.branch & zero);
    assign iord       = w_ctrl.iord;
    assign mem_write  = w_ctrl.mem_write;
    assign ir_write   = w_ctrl.ir_write;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign reg_write  = w_ctrl.reg_write;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign alu_ctrl   = w_ctrl.alu_ctrl;
    assign pc_src     = w_ctrl.pc_src;
    assign state      = r_state;
    assign retired    = r_retired;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected control words,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_en;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [1:0]       pc_src;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_src     (pc_src),
        .state      (state),
        .retired    (retired),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    //  alu_src_b[1:0], alu_ctrl[2:0], pc_src[1:0]}
    logic [14:0] act_outs;
    assign act_outs = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                       alu_src_a, alu_src_b, alu_ctrl, pc_src};

    localparam logic [14:0] O_FETCH  = 15'b1_0_0_1_0_0_0_0_01_010_00;
    localparam logic [14:0] O_DECODE = 15'b0_0_0_0_0_0_0_0_11_010_00;
    localparam logic [14:0] O_ADDR   = 15'b0_0_0_0_0_0_0_1_10_010_00;
    localparam logic [14:0] O_MEMRD  = 15'b0_1_0_0_0_0_0_0_00_000_00;
    localparam logic [14:0] O_MEMWB  = 15'b0_0_0_0_0_1_1_0_00_000_00;
    localparam logic [14:0] O_MEMWR  = 15'b0_1_1_0_0_0_0_0_00_000_00;
    localparam logic [14:0] O_EXSUB  = 15'b0_0_0_0_0_0_0_1_00_110_00;
    localparam logic [14:0] O_ALUWB  = 15'b0_0_0_0_1_0_1_0_00_000_00;
    localparam logic [14:0] O_BRZ1   = 15'b1_0_0_0_0_0_0_1_00_110_01;
    localparam logic [14:0] O_BRZ0   = 15'b0_0_0_0_0_0_0_1_00_110_01;
    localparam logic [14:0] O_ADDIWB = 15'b0_0_0_0_0_0_1_0_00_000_00;
    localparam logic [14:0] O_JUMP   = 15'b1_0_0_0_0_0_0_0_00_000_10;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] outs;
        logic [31:0] ret;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_pass;
    logic [31:0] exp_ret;
    logic        exp_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("state",   32'(state),    32'(e.st));
            check("outputs", 32'(act_outs), 32'(e.outs));
            check("retired", retired,       e.ret);
            check("illegal", 32'(illegal),  32'(e.ill));
        end
    end

    // Push the expectation for the current cycle, then advance to just after the next edge.
    task automatic step(input logic [3:0] st, input logic [14:0] outs);
        exp_t e;
        e.st   = st;
        e.outs = outs;
        e.ret  = exp_ret;
        e.ill  = exp_ill;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic report(input string name, input int cycles);
        $display("instr %-8s op=%b fn=%b cycles=%0d retired_exp=%0d illegal_exp=%0b",
                 name, opcode, funct, cycles, exp_ret, exp_ill);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_ret  = '0;
        exp_ill  = 1'b0;
        rst_n    = 1'b0;
        opcode   = 6'b000000;
        funct    = 6'b000000;
        zero     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state",   32'(state),    32'd0);
        check("reset_retired", retired,       32'd0);
        check("reset_illegal", 32'(illegal),  32'd0);
        check("reset_outputs", 32'(act_outs), 32'(O_FETCH));
        rst_n = 1'b1;

        opcode = 6'b100011; funct = 6'b000000; zero = 1'b0;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd2, O_ADDR);
        step(4'd3, O_MEMRD); step(4'd4, O_MEMWB);
        exp_ret++;
        report("lw", 5);

        opcode = 6'b000000; funct = 6'b100010;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd6, O_EXSUB); step(4'd7, O_ALUWB);
        exp_ret++;
        report("sub", 4);

        opcode = 6'b000100; funct = 6'b000000; zero = 1'b1;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd8, O_BRZ1);
        exp_ret++;
        report("beq_z1", 3);

        zero = 1'b0;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd8, O_BRZ0);
        exp_ret++;
        report("beq_z0", 3);

        opcode = 6'b111111; funct = 6'b000000;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE);
        exp_ill = 1'b1;
        report("ill_op", 2);

        opcode = 6'b000000; funct = 6'b000111;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE);
        report("ill_fn", 2);

        opcode = 6'b101011; funct = 6'b000000;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd2, O_ADDR); step(4'd5, O_MEMWR);
        exp_ret++;
        report("sw", 4);

        opcode = 6'b001000;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd9, O_ADDR); step(4'd10, O_ADDIWB);
        exp_ret++;
        report("addi", 4);

        opcode = 6'b000010;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd11, O_JUMP);
        exp_ret++;
        report("j", 3);

        // lw interrupted by reset while in MEMRD
        opcode = 6'b100011;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd2, O_ADDR);
        begin
            exp_t e;
            e.st = 4'd3; e.outs = O_MEMRD; e.ret = exp_ret; e.ill = exp_ill;
            sb_q.push_back(e);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state",    32'(state),    32'd0);
        check("async_rst_retired",  retired,       32'd0);
        check("async_rst_illegal",  32'(illegal),  32'd0);
        check("async_rst_ir_write", 32'(ir_write), 32'd1);
        exp_ret = '0;
        exp_ill = 1'b0;
        report("lw_abort", 4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'd0, O_FETCH); step(4'd1, O_DECODE); step(4'd2, O_ADDR);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle MIPS-subset datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the mux selects, the write enables and the 3-bit ALU operation code consumed by the ALU.
- Consumes the ALU zero flag for beq, and counts retired and illegal instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26] from instruction register; stable from DECODE until the instruction ends.
- funct  input  6  instr[5:0] from instruction register; same stability rule as opcode.
- zero  input  1  ALU zero flag.
- pc_en  output  1  PC load enable = pc_write | (branch & zero); combinational.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  output  1  data memory write strobe.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write data select: 0 = ALUOut, 1 = memory data.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU operand a: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU operand b: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_ctrl  output  3  ALU code: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state, for debug.
- retired  output  CNT_W  count of completed legal instructions; wraps modulo 2^CNT_W.
- illegal  output  1  sticky flag: an unsupported opcode or funct was decoded.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH(0), retired=0, illegal=0.
  - All outputs take FETCH-state values.
  - Reset mid-instruction aborts it with no further writes.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
  - Codes 12-15 are unreachable; if entered, the next state is FETCH and all outputs are 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE dispatches on opcode:
    - 100011 (lw) and 101011 (sw) -> MEMADR.
    - 000000 with funct in {100000, 100010, 100100, 100101, 101010} -> EXEC.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JUMP.
    - Anything else -> FETCH and set illegal.
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB.
  - EXEC -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH, and retired increments in that same edge.
- Outputs are Moore, a function of state only, except alu_ctrl in EXEC (from funct) and pc_en (uses zero).
- Every output defaults to 0; per-state assertions:
  - FETCH: ir_write=1, pc_write=1, alu_src_b=01, alu_ctrl=010.
  - DECODE: alu_src_b=11, alu_ctrl=010.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=010.
  - MEMRD: iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - MEMWR: iord=1, mem_write=1.
  - EXEC: alu_src_a=1, alu_src_b=00; alu_ctrl from funct: add 010, sub 110, and 000, or 001, slt 111.
  - ALUWB: reg_write=1, reg_dst=1.
  - BRANCH: alu_src_a=1, alu_ctrl=110, pc_src=01, branch=1.
  - ADDIWB: reg_write=1.
  - JUMP: pc_src=10, pc_write=1.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 (not counted).
- pc_en:
  - BRANCH: equals zero in the same cycle.
  - FETCH and JUMP: 1.
  - All other states: 0.
- illegal is cleared only by reset.
- At most one write enable (mem_write, reg_write, ir_write) is asserted in any state.

Test Plan:
- Reset asserted mid-MEMRD (state=3) -> state=0 immediately (asynchronous), retired=0, illegal=0, and ir_write=1 once rst_n is released.
- lw (opcode 100011) after reset -> states 0,1,2,3,4,0; MEMWB has reg_write=1, mem_to_reg=1; retired=1 after 5 cycles.
- R-type sub (opcode 000000, funct 100010) -> EXEC has alu_ctrl=110, alu_src_a=1, alu_src_b=00; ALUWB has reg_dst=1, reg_write=1; retired +1 after 4 cycles.
- beq in BRANCH with zero=1 -> pc_en=1, pc_src=01; rerun with zero=0 -> pc_en=0; both runs return to FETCH after 3 cycles.
- opcode 111111, and separately opcode 000000 with funct 000111 -> DECODE->FETCH, illegal=1 and stays 1, retired unchanged, no write enable asserted.
- Sequence sw, addi, j -> per-instruction latencies 4, 4, 3; mem_write=1 only in MEMWR; JUMP has pc_src=10 and pc_en=1; retired=3.
